stream_frame_sequencer: RTL
===========================

# stream_frame_sequencer

Front-end controller for `stream_neural_net`. It takes the raw VSYNC/HSYNC-framed pixel stream, checks frame geometry, and drives the net with a registered pixel bus, pixel index, and start/last strobes. It then waits for the net's completion, captures the classification, and reports it with a one-cycle valid pulse. Malformed frames are rejected and flagged.

## Interface
Parameters:
- `IMG_W`, 28, active pixels per line
- `IMG_H`, 28, active lines per frame
- `dataWidth`, 16, pixel width (Q-format is opaque to this block)
- `RES_W`, 4, classification result width
- `TIMEOUT`, 4096, max cycles to wait for `net_done` after the last pixel
- `IDX_W`, $clog2(IMG_W*IMG_H), pixel index width (10 at defaults)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `VSYNC` in 1: high for the whole frame
- `HSYNC` in 1: high while line pixels are valid; one pixel per cycle
- `pix_in` in dataWidth: pixel sampled when VSYNC&HSYNC
- `net_done` in 1: net completion pulse (or level, first cycle counts)
- `net_result` in RES_W: net classification, valid with `net_done`
- `pix_out` out dataWidth: registered pixel to the net
- `pix_valid` out 1: `pix_out` valid this cycle
- `pix_idx` out IDX_W: row*IMG_W+col of `pix_out`
- `net_start` out 1: pulse coincident with pixel 0
- `net_last` out 1: pulse coincident with pixel IMG_W*IMG_H-1
- `result` out RES_W: last captured classification, held
- `result_valid` out 1: one-cycle pulse when `result` updates
- `frame_err` out 2: sticky until next frame start; 0 none, 1 bad line length, 2 bad line count/early VSYNC fall, 3 net timeout
- `busy` out 1: high outside IDLE
- `frames_done` out 16: count of successfully classified frames, wraps

## Operation
- FSM states:
  - IDLE -> FRAME on a VSYNC rising edge, registered-edge detect.
  - FRAME: pixel accept, col/row counters. Goes to WAIT_NET after the last pixel of line IMG_H-1 is accepted. Goes to DRAIN on error.
  - WAIT_NET: timer counts from 0; on `net_done`, capture and go to IDLE. On timer == TIMEOUT-1, `frame_err`=3 and go to IDLE.
  - DRAIN: ignore pixels until VSYNC low, then go to IDLE.
- Entering FRAME clears col, row, timer and `frame_err`.
- Accepted pixel (FRAME & VSYNC & HSYNC & col<IMG_W): register the pixel to `pix_out`, assert `pix_valid`, and set `pix_idx`=row*IMG_W+col (running counter, no multiplier). Then col++.
- A pixel with col==IMG_W during HSYNC is an overlong line: `frame_err`=1, go to DRAIN.
- On an HSYNC falling edge with col!=IMG_W: `frame_err`=1, go to DRAIN. With col==IMG_W: row++, col=0.
- VSYNC falling in FRAME before completion: `frame_err`=2, go to DRAIN. An HSYNC edge with row==IMG_H also gives `frame_err`=2.
- A VSYNC rise in WAIT_NET is ignored; that frame is dropped, with no error. The block only re-arms in IDLE.
- `net_done` outside WAIT_NET is ignored.
- Capture: `result`<=`net_result`, `result_valid`=1 for one cycle, `frames_done`++ (mod 2^16).
- Reset values: all outputs 0, state IDLE, counters 0, edge-detect registers 0. Reset mid-frame aborts immediately; after reset, a VSYNC that is already high does not start a frame until it goes low and rises again.

## Timing
- Pixel latency is 1 cycle: a pixel sampled at edge N appears on `pix_out`/`pix_valid`/`pix_idx` after edge N, i.e. valid during cycle N+1.
- `net_start` is in the same cycle as `pix_idx`==0. `net_last` is in the same cycle as `pix_idx`==IMG_W*IMG_H-1.
- Pixel 0 may be in the first cycle HSYNC is high after a VSYNC rise; the edge detect must not lose it.
- `result_valid` rises the cycle after `net_done` is sampled in WAIT_NET.
- Timeout: `frame_err`=3 when `net_done` is absent for TIMEOUT cycles counted from the WAIT_NET entry cycle.
- `busy` falls the cycle after the IDLE transition.

## Test plan
- Nominal frame: VSYNC high 5 cycles; 28 lines of 28 pixels (pixel value = idx); HSYNC low 4 cycles between lines; `net_done` 50 cycles after the last pixel with result 7 -> 784 `pix_valid` pulses with `pix_idx` 0..783 matching data, `net_start` at idx 0, `net_last` at 783, `result`=7, one `result_valid` pulse, `frames_done`=1, `frame_err`=0.
- Short line: line 3 has 27 pixels -> `frame_err`=1, no `pix_valid` after the error until VSYNC falls, state IDLE; the next good frame classifies normally and clears `frame_err`.
- Early VSYNC fall after 10 lines -> `frame_err`=2, no `result_valid`; 29th line present on a good frame -> `frame_err`=2.
- Net timeout: no `net_done` with TIMEOUT=64 -> `frame_err`=3 exactly 64 cycles after WAIT_NET entry, `frames_done` unchanged; a late `net_done` is then ignored.
- Ten back-to-back frames, `net_done` 20 cycles after each last pixel -> `frames_done`=10; a VSYNC rising while waiting drops that frame, `frames_done` stays at the count of classified frames.
- Reset asserted mid-line 14 -> all outputs 0 asynchronously; with VSYNC still high after release, no `pix_valid` until a fresh VSYNC rise.

Source files
------------

// File: rtl/stream_frame_sequencer.sv
// Front end for stream_neural_net: checks VSYNC/HSYNC frame geometry, streams pixels with
// index and start/last strobes, then waits for the net and reports its classification.
module stream_frame_sequencer #(
  parameter int unsigned IMG_W     = 28,
  parameter int unsigned IMG_H     = 28,
  parameter int unsigned dataWidth = 16,
  parameter int unsigned RES_W     = 4,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned IDX_W     = $clog2(IMG_W * IMG_H)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 VSYNC,
  input  logic                 HSYNC,
  input  logic [dataWidth-1:0] pix_in,
  input  logic                 net_done,
  input  logic [RES_W-1:0]     net_result,
  output logic [dataWidth-1:0] pix_out,
  output logic                 pix_valid,
  output logic [IDX_W-1:0]     pix_idx,
  output logic                 net_start,
  output logic                 net_last,
  output logic [RES_W-1:0]     result,
  output logic                 result_valid,
  output logic [1:0]           frame_err,
  output logic                 busy,
  output logic [15:0]          frames_done
);

  localparam int unsigned COL_W = $clog2(IMG_W + 1);
  localparam int unsigned ROW_W = $clog2(IMG_H + 1);
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [COL_W-1:0] COL_END  = COL_W'(IMG_W);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrLine    = 2'd1;
  localparam logic [1:0] ErrCount   = 2'd2;
  localparam logic [1:0] ErrTimeout = 2'd3;

  typedef enum logic [1:0] {StIdle, StFrame, StWaitNet, StDrain} state_e;

  state_e               state_q, state_d;
  logic [COL_W-1:0]     col_q, col_d, col_e;
  logic [ROW_W-1:0]     row_q, row_d, row_e;
  logic [IDX_W-1:0]     idx_q, idx_d, idx_e;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 vsync_q, hsync_q, armed_q;
  logic                 vs_low_q, vs_low_d;
  logic                 hs_prev, in_frame, vsync_rise;
  logic [dataWidth-1:0] pix_out_q, pix_out_d;
  logic                 pix_valid_q, pix_valid_d;
  logic [IDX_W-1:0]     pix_idx_q, pix_idx_d;
  logic                 net_start_q, net_start_d;
  logic                 net_last_q, net_last_d;
  logic [RES_W-1:0]     result_q, result_d;
  logic                 result_valid_q, result_valid_d;
  logic [1:0]           frame_err_q, frame_err_d;
  logic [15:0]          frames_done_q, frames_done_d;

  // armed_q blocks a VSYNC that is already high out of reset from looking like a rise.
  assign vsync_rise = armed_q & VSYNC & ~vsync_q;

  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    row_d          = row_q;
    idx_d          = idx_q;
    timer_d        = timer_q;
    vs_low_d       = vs_low_q;
    pix_out_d      = pix_out_q;
    pix_valid_d    = 1'b0;
    pix_idx_d      = pix_idx_q;
    net_start_d    = 1'b0;
    net_last_d     = 1'b0;
    result_d       = result_q;
    result_valid_d = 1'b0;
    frame_err_d    = frame_err_q;
    frames_done_d  = frames_done_q;
    in_frame       = 1'b0;
    col_e          = col_q;
    row_e          = row_q;
    idx_e          = idx_q;
    hs_prev        = hsync_q;

    unique case (state_q)
      StIdle: begin
        // Frame start falls through to pixel handling so a pixel on the rise cycle is kept.
        if (vsync_rise) begin
          state_d     = StFrame;
          col_e       = '0;
          row_e       = '0;
          idx_e       = '0;
          hs_prev     = 1'b0;
          timer_d     = '0;
          frame_err_d = ErrNone;
          in_frame    = 1'b1;
        end
      end
      StFrame: in_frame = 1'b1;
      StWaitNet: begin
        timer_d = timer_q + 1'b1;
        if (!VSYNC) vs_low_d = 1'b1;
        if (net_done) begin
          result_d       = net_result;
          result_valid_d = 1'b1;
          frames_done_d  = frames_done_q + 16'd1;
          state_d        = StIdle;
        end else if (VSYNC && HSYNC && !hsync_q && !vs_low_q) begin
          // Another line inside the same VSYNC: too many lines.
          frame_err_d = ErrCount;
          state_d     = StDrain;
        end else if (timer_q == TMR_LAST) begin
          frame_err_d = ErrTimeout;
          state_d     = StIdle;
        end
      end
      StDrain: begin
        if (!VSYNC) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (in_frame) begin
      col_d = col_e;
      row_d = row_e;
      idx_d = idx_e;
      if (!VSYNC) begin
        frame_err_d = ErrCount;
        state_d     = StDrain;
      end else if (HSYNC) begin
        if (col_e == COL_END) begin
          frame_err_d = ErrLine;
          state_d     = StDrain;
        end else begin
          pix_out_d   = pix_in;
          pix_valid_d = 1'b1;
          pix_idx_d   = idx_e;
          net_start_d = (idx_e == '0);
          col_d       = col_e + 1'b1;
          idx_d       = idx_e + 1'b1;
          if (row_e == ROW_LAST && col_e == COL_LAST) begin
            net_last_d = 1'b1;
            timer_d    = '0;
            vs_low_d   = 1'b0;
            state_d    = StWaitNet;
          end
        end
      end else if (hs_prev) begin
        if (col_e != COL_END) begin
          frame_err_d = ErrLine;
          state_d     = StDrain;
        end else begin
          row_d = row_e + 1'b1;
          col_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      col_q          <= '0;
      row_q          <= '0;
      idx_q          <= '0;
      timer_q        <= '0;
      vsync_q        <= 1'b0;
      hsync_q        <= 1'b0;
      armed_q        <= 1'b0;
      vs_low_q       <= 1'b0;
      pix_out_q      <= '0;
      pix_valid_q    <= 1'b0;
      pix_idx_q      <= '0;
      net_start_q    <= 1'b0;
      net_last_q     <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      frame_err_q    <= ErrNone;
      frames_done_q  <= '0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      idx_q          <= idx_d;
      timer_q        <= timer_d;
      vsync_q        <= VSYNC;
      hsync_q        <= HSYNC;
      if (!VSYNC) armed_q <= 1'b1;
      vs_low_q       <= vs_low_d;
      pix_out_q      <= pix_out_d;
      pix_valid_q    <= pix_valid_d;
      pix_idx_q      <= pix_idx_d;
      net_start_q    <= net_start_d;
      net_last_q     <= net_last_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      frame_err_q    <= frame_err_d;
      frames_done_q  <= frames_done_d;
    end
  end

  assign pix_out      = pix_out_q;
  assign pix_valid    = pix_valid_q;
  assign pix_idx      = pix_idx_q;
  assign net_start    = net_start_q;
  assign net_last     = net_last_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign frame_err    = frame_err_q;
  assign busy         = (state_q != StIdle);
  assign frames_done  = frames_done_q;

endmodule
